psum_norm: RTL and testbench

PSUM_NORM -- requirements
Module: psum_norm

---
 rtl/norm_pkg.sv | 19 +
 rtl/seq_divider.sv | 72 +++++++
 rtl/psum_norm.sv | 167 ++++++++++++++++
 tb/tb_psum_norm.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared constants and the controller state type for the psum row normalizer.
// NUM_W is the numerator width and also the number of divider cycles per lane.
package norm_pkg;

    localparam int COL     = 8;
    localparam int BW_PSUM = 12;
    localparam int FRAC    = 8;
    localparam int SUM_BW  = 16;
    localparam int OUT_BW  = FRAC + 1;
    localparam int NUM_W   = BW_PSUM + FRAC + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, exactly NUM_W cycles
// per division. The start cycle already performs the first step, so a new
// division can be launched on the same edge that the previous result is taken.
module seq_divider
    import norm_pkg::*;
#(
    parameter int NUM_W_P = NUM_W,
    parameter int DEN_W   = SUM_BW,
    parameter int QUO_W   = OUT_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NUM_W_P-1:0] numerator,
    input  logic [DEN_W-1:0]   denominator,
    output logic               done,
    output logic [QUO_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(NUM_W_P + 1);

    logic [DEN_W-1:0]   rem_q, rem_d;
    logic [NUM_W_P-1:0] num_q, num_d;
    logic [DEN_W-1:0]   den_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               active_q;

    logic [DEN_W-1:0]   rem_src;
    logic [NUM_W_P-1:0] num_src;
    logic [DEN_W-1:0]   den_src;
    logic [DEN_W:0]     r_sh;
    logic [DEN_W-1:0]   r_diff;
    logic               fits;

    // One restoring step on either the fresh operands (start) or the running state.
    always_comb begin
        rem_src = start ? '0 : rem_q;
        num_src = start ? numerator : num_q;
        den_src = start ? denominator : den_q;
        r_sh    = {rem_src, num_src[NUM_W_P-1]};
        fits    = (r_sh >= {1'b0, den_src});
        // Remainder stays below the divisor, so the low bits of the difference suffice.
        r_diff  = r_sh[DEN_W-1:0] - den_src;
        rem_d   = fits ? r_diff : r_sh[DEN_W-1:0];
        num_d   = {num_src[NUM_W_P-2:0], fits};
    end

    // Divider state: load on start, then step until NUM_W bits are produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            num_q    <= '0;
            den_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            rem_q    <= rem_d;
            num_q    <= num_d;
            den_q    <= denominator;
            cnt_q    <= CNT_W'(1);
            active_q <= 1'b1;
        end else if (active_q && (cnt_q != CNT_W'(NUM_W_P))) begin
            rem_q    <= rem_d;
            num_q    <= num_d;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign done     = active_q && (cnt_q == CNT_W'(NUM_W_P));
    assign quotient = num_q[QUO_W-1:0];

endmodule

// File: rtl/psum_norm.sv
// Psum row normalizer: takes a row of signed psum lanes, computes the sum of
// magnitudes, then divides each |lane| << frac by that sum, one lane at a time
// through a shared sequential divider.
// Build option: define NORM_ROUND_EN to round half-up (adds sum/2 to each
// numerator); otherwise the quotient is truncated. Timing is identical.
module psum_norm
    import norm_pkg::*;
#(
    parameter int col     = COL,
    parameter int bw_psum = BW_PSUM,
    parameter int frac    = FRAC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [col*bw_psum-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [col*(frac+1)-1:0]   out_data,
    output logic [SUM_BW-1:0]         sum_out,
    output logic                      busy
);

    localparam int OUTW   = frac + 1;
    localparam int NUMW   = bw_psum + frac + 1;
    localparam int LANE_W = (col > 1) ? $clog2(col) : 1;

    state_t                       state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [SUM_BW-1:0]            sum_q;
    logic [col*bw_psum-1:0]       row_q;

    logic [col-1:0][bw_psum-1:0]  abs_w;
    logic [SUM_BW-1:0]            sum_comb;
    logic [LANE_W-1:0]            lane_sel;
    logic [SUM_BW-1:0]            den_src;
    logic [NUMW-1:0]              numerator;
    logic                         div_start;
    logic                         div_done;
    logic [OUTW-1:0]              div_quo;
    logic                         cap_en;
    logic                         clr_out;

    // Per-lane magnitude of the registered row; -2^(bw-1) maps to 2^(bw-1) unsigned.
    for (genvar gi = 0; gi < col; gi++) begin : g_abs
        logic [bw_psum-1:0] lane_w;
        assign lane_w    = row_q[bw_psum*gi +: bw_psum];
        assign abs_w[gi] = lane_w[bw_psum-1] ? (bw_psum'(0) - lane_w) : lane_w;
    end

    // Sum of magnitudes; the widest case fits in SUM_BW without overflow.
    always_comb begin
        sum_comb = '0;
        for (int k = 0; k < col; k++) begin
            sum_comb = sum_comb + {{(SUM_BW-bw_psum){1'b0}}, abs_w[k]};
        end
    end

    // Numerator for the lane being launched into the divider.
    always_comb begin
        numerator = {{(NUMW-bw_psum){1'b0}}, abs_w[lane_sel]} << frac;
`ifdef NORM_ROUND_EN
        numerator = numerator + {{(NUMW-SUM_BW){1'b0}}, den_src >> 1};
`endif
    end

    // Next-state logic: ACC launches lane 0 directly with the combinational sum,
    // DIV chains each lane's capture with the next lane's launch.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        lane_sel  = lane_q + LANE_W'(1);
        den_src   = sum_q;
        div_start = 1'b0;
        cap_en    = 1'b0;
        clr_out   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                lane_sel = '0;
                den_src  = sum_comb;
                lane_d   = '0;
                if (sum_comb == '0) begin
                    clr_out = 1'b1;
                    state_d = DONE;
                end else begin
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    cap_en = 1'b1;
                    if (lane_q == LANE_W'(col - 1)) begin
                        state_d = DONE;
                    end else begin
                        div_start = 1'b1;
                        lane_d    = lane_q + LANE_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; the row is only captured while idle, the sum only in ACC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
            sum_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (state_q == ACC) begin
                sum_q <= sum_comb;
            end
            if ((state_q == IDLE) && in_valid) begin
                row_q <= in_data;
            end
        end
    end

    seq_divider #(
        .NUM_W_P (NUMW),
        .DEN_W   (SUM_BW),
        .QUO_W   (OUTW)
    ) u_div (
        .clk         (clk),
        .reset       (reset),
        .start       (div_start),
        .numerator   (numerator),
        .denominator (den_src),
        .done        (div_done),
        .quotient    (div_quo)
    );

    // Output lanes: cleared for a zero-sum row, otherwise written as each quotient completes.
    for (genvar gi = 0; gi < col; gi++) begin : g_out
        logic [OUTW-1:0] out_lane_q;
        always_ff @(posedge clk) begin
            if (reset || clr_out) begin
                out_lane_q <= '0;
            end else if (cap_en && (lane_q == LANE_W'(gi))) begin
                out_lane_q <= div_quo;
            end
        end
        assign out_data[OUTW*gi +: OUTW] = out_lane_q;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_psum_norm.sv
// Directed bench for psum_norm. Cycle numbering: the accepting edge opens
// cycle 1 (the ACC cycle); each later edge advances the count by one.
module tb_psum_norm;

    localparam int COL = 8;
    localparam int BW  = 12;
    localparam int OB  = 9;

`ifdef NORM_ROUND_EN
    localparam int LANE1_SMALL = 171;
`else
    localparam int LANE1_SMALL = 170;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [COL*BW-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [COL*OB-1:0]   out_data;
    logic [15:0]         sum_out;
    logic                busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psum_norm dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sum_out   (sum_out),
        .busy      (busy)
    );

    function automatic logic [COL*BW-1:0] mk_row(input int l[COL]);
        logic [COL*BW-1:0] r;
        r = '0;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(l[k]);
        return r;
    endfunction

    // Offer one row, then wait (bounded) for out_valid; returns the cycle it appeared.
    task automatic do_row(input logic [COL*BW-1:0] d, output int cyc);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL row_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
        end
        $display("row in=%h out_valid_cycle=%0d sum=%0d out=%h", d, cyc, sum_out, out_data);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
        checks++; if (sum_out !== 16'd0) begin errors++; $display("FAIL reset_sum: got %0d need 0", sum_out); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h need 0", out_data); end
    endtask

    task automatic test_all_ones();
        int l[COL] = '{1, 1, 1, 1, 1, 1, 1, 1};
        int cyc;
        do_row(mk_row(l), cyc);
        checks++; if (cyc != 170) begin errors++; $display("FAIL ones_latency: got %0d need 170", cyc); end
        checks++; if (sum_out !== 16'd8) begin errors++; $display("FAIL ones_sum: got %0d need 8", sum_out); end
        for (int k = 0; k < COL; k++) begin
            checks++;
            if (out_data[k*OB +: OB] !== 9'd32) begin
                errors++; $display("FAIL ones_lane%0d: got %0d need 32", k, out_data[k*OB +: OB]);
            end
        end
        consume();
    endtask

    task automatic test_neg_max();
        int l[COL] = '{-2048, 0, 0, 0, 0, 0, 0, 0};
        int cyc;
        int e;
        do_row(mk_row(l), cyc);
        checks++; if (cyc != 170) begin errors++; $display("FAIL negmax_latency: got %0d need 170", cyc); end
        checks++; if (sum_out !== 16'd2048) begin errors++; $display("FAIL negmax_sum: got %0d need 2048", sum_out); end
        for (int k = 0; k < COL; k++) begin
            e = (k == 0) ? 256 : 0;
            checks++;
            if (out_data[k*OB +: OB] !== OB'(e)) begin
                errors++; $display("FAIL negmax_lane%0d: got %0d need %0d", k, out_data[k*OB +: OB], e);
            end
        end
        consume();
    endtask

    task automatic test_zero();
        int l[COL] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int cyc;
        do_row(mk_row(l), cyc);
        checks++; if (cyc != 2) begin errors++; $display("FAIL zero_latency: got %0d need 2", cyc); end
        checks++; if (sum_out !== 16'd0) begin errors++; $display("FAIL zero_sum: got %0d need 0", sum_out); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL zero_out: got %h need 0", out_data); end
        consume();
    endtask

    task automatic test_small_ignore_input();
        int l[COL]    = '{1, 2, 0, 0, 0, 0, 0, 0};
        int junk[COL] = '{-1, -1, -1, -1, -1, -1, -1, -1};
        int e[COL]    = '{85, LANE1_SMALL, 0, 0, 0, 0, 0, 0};
        int cyc;
        in_data  = mk_row(l);
        in_valid = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        // Keep offering a different row while busy; it must be ignored.
        for (int i = 0; i < 30; i++) begin
            in_valid = i[0];
            in_data  = mk_row(junk);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got %b need 0", in_ready); end
        while (out_valid !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("row small out_valid_cycle=%0d sum=%0d out=%h", cyc, sum_out, out_data);
        checks++; if (cyc != 170) begin errors++; $display("FAIL small_latency: got %0d need 170", cyc); end
        checks++; if (sum_out !== 16'd3) begin errors++; $display("FAIL small_sum: got %0d need 3", sum_out); end
        for (int k = 0; k < COL; k++) begin
            checks++;
            if (out_data[k*OB +: OB] !== OB'(e[k])) begin
                errors++; $display("FAIL small_lane%0d: got %0d need %0d", k, out_data[k*OB +: OB], e[k]);
            end
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int l[COL] = '{1, 1, 1, 1, 1, 1, 1, 1};
        int z[COL] = '{0, 0, 0, 0, 0, 0, 0, 0};
        logic [COL*OB-1:0] exp_out;
        int cyc;
        for (int k = 0; k < COL; k++) exp_out[k*OB +: OB] = 9'd32;
        do_row(mk_row(l), cyc);
        // Hold off the consumer for 10 cycles; everything must stay put.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid%0d: got %b need 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready%0d: got %b need 0", i, in_ready); end
            checks++; if (out_data !== exp_out) begin errors++; $display("FAIL hold_data%0d: got %h need %h", i, out_data, exp_out); end
            checks++; if (sum_out !== 16'd8) begin errors++; $display("FAIL hold_sum%0d: got %0d need 8", i, sum_out); end
        end
        consume();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_hs_in_ready: got %b need 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_hs_valid: got %b need 0", out_valid); end
        do_row(mk_row(z), cyc);
        checks++; if (cyc != 2) begin errors++; $display("FAIL b2b_latency: got %0d need 2", cyc); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL b2b_out: got %h need 0", out_data); end
        consume();
    endtask

    task automatic test_reset_mid_div();
        int l[COL] = '{1, 1, 1, 1, 1, 1, 1, 1};
        int cyc;
        bit seen;
        in_data  = mk_row(l);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // DIV cycle n is row cycle n+1; stop at DIV cycle 50.
        repeat (50) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL middiv_busy: got %b need 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset applied mid-DIV busy=%b in_ready=%b", busy, in_ready);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b need 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b need 1", in_ready); end
        checks++; if (sum_out !== 16'd0) begin errors++; $display("FAIL abort_sum: got %0d need 0", sum_out); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL abort_out: got %h need 0", out_data); end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b need 0", seen); end
        do_row(mk_row(l), cyc);
        checks++; if (cyc != 170) begin errors++; $display("FAIL after_abort_latency: got %0d need 170", cyc); end
        checks++; if (sum_out !== 16'd8) begin errors++; $display("FAIL after_abort_sum: got %0d need 8", sum_out); end
        for (int k = 0; k < COL; k++) begin
            checks++;
            if (out_data[k*OB +: OB] !== 9'd32) begin
                errors++; $display("FAIL after_abort_lane%0d: got %0d need 32", k, out_data[k*OB +: OB]);
            end
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_neg_max();
        test_zero();
        test_small_ignore_input();
        test_back_to_back();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
